// File: rtl/ranging_uart_pkg.sv
// Shared constants, FSM state encoding and helpers for the ranging UART line transmitter.
package ranging_uart_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_C     = 8'h63;
  localparam logic [7:0] ASCII_M     = 8'h6D;
  localparam logic [7:0] ASCII_I     = 8'h69;
  localparam logic [7:0] ASCII_N     = 8'h6E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Clocks per bit from a 50 MHz system clock.
  localparam int BAUD_DIV_9600   = 5208;
  localparam int BAUD_DIV_115200 = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // BCD nibble to printable character; A..F are flagged as '?'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
    if (nib > 4'd9) begin
      return ASCII_QMARK;
    end
    return ASCII_ZERO + {4'd0, nib};
  endfunction

endpackage

// File: rtl/ranging_uart_baud_gen.sv
// Bit-period generator: counts 0..BAUD_DIV-1 while enabled and ticks on the last count.
module ranging_uart_baud_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i && !restart_i && (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ranging_uart_frame_tx.sv
// Sends a packed BCD distance as an ASCII line "<digits> cm|in\r\n" over UART.
// Define RANGING_UART_PARITY_EN to insert an even parity bit after the data bits.
module ranging_uart_frame_tx
  import ranging_uart_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int BAUD_DIV   = BAUD_DIV_9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Data_available_i,
  input  logic [4*NUM_DIGITS-1:0] Data_i,
  input  logic                    cm_or_inch_i,
  output logic                    Busy_o,
  output logic                    Done_o,
  output logic                    Tx_o
);

  localparam int NUM_CHARS = NUM_DIGITS + 5;
  localparam int CI_W      = $clog2(NUM_CHARS);
  localparam int BI_W      = $clog2(DATA_BITS + 1);

  localparam logic [CI_W-1:0] IDX_SPACE = CI_W'(NUM_DIGITS);
  localparam logic [CI_W-1:0] IDX_UNIT0 = CI_W'(NUM_DIGITS + 1);
  localparam logic [CI_W-1:0] IDX_UNIT1 = CI_W'(NUM_DIGITS + 2);
  localparam logic [CI_W-1:0] IDX_CR    = CI_W'(NUM_DIGITS + 3);
  localparam logic [CI_W-1:0] IDX_LAST  = CI_W'(NUM_CHARS - 1);

  localparam logic [BI_W-1:0] LAST_DATA_BIT = BI_W'(DATA_BITS - 1);
  localparam logic [BI_W-1:0] LAST_STOP_BIT = BI_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef RANGING_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
  localparam logic [7:0] DATA_MASK = (DATA_BITS == 8) ? 8'hFF : 8'h7F;
`endif

  logic [2:0]              state_q,    state_d;
  logic [4*NUM_DIGITS-1:0] data_q,     data_d;
  logic                    unit_q,     unit_d;
  logic [CI_W-1:0]         char_idx_q, char_idx_d;
  logic [BI_W-1:0]         bit_idx_q,  bit_idx_d;
  logic                    tx_q,       tx_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;

  logic                    tick;
  logic [CI_W-1:0]         first_idx;
  logic [7:0]              char_byte;
  logic [7:0]              char_shift;
`ifdef RANGING_UART_PARITY_EN
  logic                    parity_bit;
`endif

  ranging_uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk_i     (Clk_i),
    .rst_ni    (Reset_i),
    .en_i      (state_q != S_IDLE),
    .restart_i (state_q == S_LOAD),
    .tick_o    (tick)
  );

  // Leading-zero suppression: the LSD is always shown, invalid nibbles count as nonzero.
  always_comb begin
    first_idx = CI_W'(NUM_DIGITS - 1);
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (data_q[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) begin
        first_idx = CI_W'(i);
      end
    end
  end

  always_comb begin
    char_byte = ASCII_LF;
    if (char_idx_q < IDX_SPACE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (char_idx_q == CI_W'(i)) begin
          char_byte = digit_ascii(data_q[4*(NUM_DIGITS-1-i) +: 4]);
        end
      end
    end else if (char_idx_q == IDX_SPACE) begin
      char_byte = ASCII_SPACE;
    end else if (char_idx_q == IDX_UNIT0) begin
      char_byte = unit_q ? ASCII_I : ASCII_C;
    end else if (char_idx_q == IDX_UNIT1) begin
      char_byte = unit_q ? ASCII_N : ASCII_M;
    end else if (char_idx_q == IDX_CR) begin
      char_byte = ASCII_CR;
    end
  end

  assign char_shift = char_byte >> bit_idx_q;
`ifdef RANGING_UART_PARITY_EN
  assign parity_bit = ^(char_byte & DATA_MASK);
`endif

  // Tx is registered from the current state, so the line lags the FSM by one clock.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    unit_d     = unit_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (Data_available_i && !done_q) begin
          data_d  = Data_i;
          unit_d  = cm_or_inch_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        char_idx_d = first_idx;
        bit_idx_d  = '0;
        state_d    = S_START;
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = char_shift[0];
        if (tick) begin
          if (bit_idx_q == LAST_DATA_BIT) begin
            bit_idx_d = '0;
`ifdef RANGING_UART_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BI_W'(1);
          end
        end
      end
`ifdef RANGING_UART_PARITY_EN
      S_PARITY: begin
        tx_d = parity_bit;
        if (tick) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_idx_q == LAST_STOP_BIT) begin
            bit_idx_d = '0;
            if (char_idx_q == IDX_LAST) begin
              char_idx_d = '0;
              state_d    = S_IDLE;
            end else begin
              char_idx_d = char_idx_q + CI_W'(1);
              state_d    = S_START;
            end
          end else begin
            bit_idx_d = bit_idx_q + BI_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_q == S_STOP) && (state_d == S_IDLE);

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      unit_q     <= 1'b0;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      unit_q     <= unit_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Busy_o = busy_q;
  assign Done_o = done_q;
  assign Tx_o   = tx_q;

endmodule

// File: doc/ranging_uart_frame_tx.md
Name: ranging_uart_frame_tx

Overview:
- Parametrised UART transmitter for distance readings from the ranging front-end.
- Each accepted sample is a packed BCD value; the block sends it as an ASCII line: digits, space, two-letter unit, CR, LF.
- Generalises digit count, baud divisor, data bits and stop bits.
- Adds general leading-zero suppression, invalid-digit marking, a busy/done handshake and optional parity.
- Sits between the distance-to-BCD converter and the board Tx pin.

Parameters:
- NUM_DIGITS, 3, BCD digits in Data_i (1..8).
- BAUD_DIV, 5208, clocks per UART bit (50 MHz / 9600); minimum 4.
- DATA_BITS, 8, UART data bits per character (7 or 8); sent LSB first.
- STOP_BITS, 1, stop bits per character (1 or 2).

Ports:
- Clk_i  in  1  system clock.
- Reset_i  in  1  synchronous reset, active-low: sampled only on the Clk_i rising edge, asserted when 0.
- Data_available_i  in  1  one-cycle (or longer) request to send a new reading.
- Data_i  in  4*NUM_DIGITS  packed BCD, most significant digit in the top nibble.
- cm_or_inch_i  in  1  unit select: 1 = "in", 0 = "cm"; sampled with Data_i.
- Busy_o  out  1  high while a line is being sent.
- Done_o  out  1  one-cycle pulse when the last stop bit of LF completes.
- Tx_o  out  1  UART serial line, idle high.

Behaviour:
- Reset (Reset_i = 0 at a rising edge): Tx_o = 1, Busy_o = 0, Done_o = 0, state = IDLE, all counters = 0. This applies mid-frame too: the line returns high on the next edge and the partial character is abandoned.
- States:
  - IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP.
  - From STOP: back to START if more characters remain, else to IDLE.
- Accept:
  - In IDLE, Data_available_i = 1 at edge N latches Data_i and cm_or_inch_i.
  - Busy_o = 1 from edge N.
  - Requests in any other state are ignored; nothing is queued.
- LOAD:
  - Computes the first shown digit index F = index of the first nonzero digit, MS first.
  - The least significant digit is always shown, so 0 prints "0".
  - Tx_o goes low (start bit) from edge N+2.
- Line content:
  - Digits F..LSD, then 0x20, then "cm" (0x63 0x6D) or "in" (0x69 0x6E), then 0x0D, 0x0A.
  - Total characters = shown digits + 5.
- Digit mapping: nibble 0..9 -> 0x30 + n; nibble A..F -> 0x3F ('?'). Invalid nibbles count as nonzero for suppression.
- Bit timing:
  - Each bit (start, data, parity, stop) is held exactly BAUD_DIV clocks.
  - The baud counter counts 0..BAUD_DIV-1, restarts at each start bit and emits a tick at BAUD_DIV-1.
  - There are no idle gaps between characters: the next start bit immediately follows the last stop bit.
- Data order: bit 0 first. With DATA_BITS = 7, the character's bit 7 is not sent.
- Done_o pulses in the cycle the FSM enters IDLE. Busy_o falls in the same cycle.
- Data_available_i = 1 in the same cycle Done_o pulses is not accepted; it is accepted from the following cycle.
- Counter widths: baud counter $clog2(BAUD_DIV); character index $clog2(NUM_DIGITS+5); bit index $clog2(DATA_BITS+1). No wrap occurs within legal parameters.

Optional Feature:
- Macro: RANGING_UART_PARITY_EN.
- Defined: an even parity bit (XOR of the sent data bits) is inserted between the last data bit and the first stop bit, held BAUD_DIV clocks. Character length becomes 1 + DATA_BITS + 1 + STOP_BITS bits.
- Undefined: there is no PARITY state, and the character is 1 + DATA_BITS + STOP_BITS bits.

Decomposition:
- Shared package ranging_uart_pkg holds:
  - ASCII constants: zero, space, '?', 'c', 'm', 'i', 'n', CR, LF.
  - The FSM state enum.
  - Defaults for BAUD_DIV at 50 MHz for 9600 and 115200 baud.
- Sub-module: ranging_uart_baud_gen, with enable/restart in and one-cycle tick out, parametrised by BAUD_DIV.

Test Plan (BAUD_DIV = 16, DATA_BITS = 8, STOP_BITS = 1, NUM_DIGITS = 3 unless stated):
- Data_i = 12'h123, cm_or_inch_i = 0, one-cycle request:
  - decoded bytes 0x31 0x32 0x33 0x20 0x63 0x6D 0x0D 0x0A;
  - each bit 16 clocks; Busy_o high for 8*10*16 = 1280 clocks plus 1 load cycle;
  - Done_o pulses once.
- Data_i = 12'h007, cm_or_inch_i = 1 -> 0x37 0x20 0x69 0x6E 0x0D 0x0A. Data_i = 12'h000 -> 0x30 0x20 0x63 0x6D 0x0D 0x0A.
- Data_i = 12'h0A5 -> 0x3F 0x35 ... ('?' shown, no suppression of A). Changing Data_i while Busy_o = 1 does not alter the bytes in flight.
- Second request pulsed mid-line and again on the Done_o cycle: both ignored. A request one cycle after Done_o starts a new line, with its start bit 2 clocks later.
- Reset_i = 0 for one cycle during the 4th character's data bits: Tx_o = 1, Busy_o = 0 on the next edge. A subsequent request sends a complete, correct line.
- RANGING_UART_PARITY_EN defined, Data_i = 12'h001 -> '1' (0x31, three ones) sent with parity bit 1, 11 bits per character. Repeat with STOP_BITS = 2 and check 12 bits per character.
